// File: rtl/mux2_burst_arbiter_pkg.sv
// Shared types and constants for the two-requester burst arbiter.
package mux_arb_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mux2_burst_arbiter_if.sv
// Requester and downstream valid/ready bundle for the burst arbiter.
interface mux2_burst_arbiter_if;
    import mux_arb_pkg::*;

    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_last;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_last;
    logic              req1_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    // Producer/consumer side
    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  out_valid, out_data, out_last,
        output out_ready
    );

endinterface

// File: rtl/mux2_burst_arbiter_mux2to1.sv
// Plain 2:1 data mux; s=0 selects i0.
module mux2to1
    import mux_arb_pkg::*;
(
    input  logic              s,
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    output logic [DATA_W-1:0] y
);

    assign y = s ? i1 : i0;

endmodule

// File: rtl/mux2_burst_arbiter.sv
// Round-robin burst arbiter steering two valid/ready requesters onto one port.
// Optional per-requester beat statistics are enabled by ARB_STATS_EN.
module mux2_burst_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mux2_burst_arbiter_if.slave  bus,
    output logic                 sel,
    output logic                 busy
`ifdef ARB_STATS_EN
    ,
    input  logic                 stat_clear,
    output logic [STAT_W-1:0]    stat0_beats,
    output logic [STAT_W-1:0]    stat1_beats
`endif
);

    arb_state_e       state, state_d;
    logic             sel_d;
    logic             prio, prio_d;
    logic [CNT_W-1:0] beat_cnt, cnt_d;
    logic             grant_idx;
    logic             own_valid;
    logic             own_last;
    logic             other_valid;
    logic             cnt_at_max;
    logic             accept;

    mux2to1 u_mux (
        .s  (sel),
        .i0 (bus.req0_data),
        .i1 (bus.req1_data),
        .y  (bus.out_data)
    );

    // State, select, priority pointer and beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= 1'b0;
            prio     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            sel      <= sel_d;
            prio     <= prio_d;
            beat_cnt <= cnt_d;
        end
    end

    // Arbitration, burst tracking and handshake steering
    always_comb begin
        state_d         = state;
        sel_d           = sel;
        prio_d          = prio;
        cnt_d           = beat_cnt;
        grant_idx       = (state == GRANT1);
        own_valid       = 1'b0;
        own_last        = 1'b0;
        other_valid     = 1'b0;
        cnt_at_max      = (beat_cnt == CNT_W'(MAX_BURST - 1));
        accept          = 1'b0;
        bus.out_valid   = 1'b0;
        bus.out_last    = 1'b0;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req0_valid && (!bus.req1_valid || !prio)) begin
                    state_d = GRANT0;
                    sel_d   = 1'b0;
                end else if (bus.req1_valid) begin
                    state_d = GRANT1;
                    sel_d   = 1'b1;
                end
            end
            GRANT0: begin
                own_valid      = bus.req0_valid;
                own_last       = bus.req0_last;
                other_valid    = bus.req1_valid;
                bus.req0_ready = bus.out_ready;
            end
            GRANT1: begin
                own_valid      = bus.req1_valid;
                own_last       = bus.req1_last;
                other_valid    = bus.req0_valid;
                bus.req1_ready = bus.out_ready;
            end
            default: state_d = IDLE;
        endcase

        if (state == GRANT0 || state == GRANT1) begin
            bus.out_valid = own_valid;
            bus.out_last  = own_last | cnt_at_max;
            accept        = own_valid & bus.out_ready;
            if (accept) begin
                if (own_last || cnt_at_max) begin
                    cnt_d  = '0;
                    prio_d = ~grant_idx;
                    // Hand over straight to the waiting requester; a forced
                    // release with more data pending re-grants the same one.
                    if (other_valid) begin
                        state_d = grant_idx ? GRANT0 : GRANT1;
                        sel_d   = ~grant_idx;
                    end else if (!own_last) begin
                        state_d = state;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = beat_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef ARB_STATS_EN
    // Saturating accepted-beat counters; clear has priority over counting
    always_ff @(posedge clk) begin
        if (reset || stat_clear) begin
            stat0_beats <= '0;
            stat1_beats <= '0;
        end else if (accept) begin
            if (!grant_idx && stat0_beats != '1) begin
                stat0_beats <= stat0_beats + STAT_W'(1);
            end
            if (grant_idx && stat1_beats != '1) begin
                stat1_beats <= stat1_beats + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux2_burst_arbiter.sv
// Directed self-checking bench for mux2_burst_arbiter (MAX_BURST=4).
module tb_mux2_burst_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic sel;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mux2_burst_arbiter_if bus ();

`ifdef ARB_STATS_EN
    logic        stat_clear;
    logic [15:0] stat0_beats;
    logic [15:0] stat1_beats;
`endif

    mux2_burst_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .sel   (sel),
        .busy  (busy)
`ifdef ARB_STATS_EN
        ,
        .stat_clear  (stat_clear),
        .stat0_beats (stat0_beats),
        .stat1_beats (stat1_beats)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1,
                         input logic ordy);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req0_last  = l0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.req1_last  = l1;
        bus.out_ready  = ordy;
    endtask

    // Check one cycle at the falling edge, then advance past the next rising edge
    task automatic cyc(input string tag, input logic ov, input logic [7:0] od, input logic ol,
                       input logic r0, input logic r1, input logic s, input logic b);
        @(negedge clk);
        chk({tag, ".out_valid"},  32'(bus.out_valid),  32'(ov));
        chk({tag, ".req0_ready"}, 32'(bus.req0_ready), 32'(r0));
        chk({tag, ".req1_ready"}, 32'(bus.req1_ready), 32'(r1));
        chk({tag, ".sel"},        32'(sel),            32'(s));
        chk({tag, ".busy"},       32'(busy),           32'(b));
        if (ov) begin
            chk({tag, ".out_data"}, 32'(bus.out_data), 32'(od));
            chk({tag, ".out_last"}, 32'(bus.out_last), 32'(ol));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
`ifdef ARB_STATS_EN
        stat_clear = 1'b0;
`endif
        reset = 1'b1;
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        @(posedge clk);
        #1;
        cyc("rst", 0, 8'h00, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Single requester, 3-beat burst
        drive(1, 8'hA1, 0, 0, 8'h00, 0, 1);
        cyc("t1_arb", 0, 8'h00, 0, 0, 0, 0, 0);
        cyc("t1_b1", 1, 8'hA1, 0, 1, 0, 0, 1);
        drive(1, 8'hA2, 0, 0, 8'h00, 0, 1);
        cyc("t1_b2", 1, 8'hA2, 0, 1, 0, 0, 1);
        drive(1, 8'hA3, 1, 0, 8'h00, 0, 1);
        cyc("t1_b3", 1, 8'hA3, 1, 1, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        cyc("t1_idle", 0, 8'h00, 0, 0, 0, 0, 0);
        // prio is now 1: a tie goes to req1, then hands straight back
        drive(1, 8'h11, 1, 1, 8'h22, 1, 1);
        cyc("t1_tie", 0, 8'h00, 0, 0, 0, 0, 0);
        cyc("t1_prio1", 1, 8'h22, 1, 0, 1, 1, 1);
        drive(1, 8'h11, 1, 0, 8'h00, 0, 1);
        cyc("t1_back0", 1, 8'h11, 1, 1, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        cyc("t1_idle2", 0, 8'h00, 0, 0, 0, 0, 0);

        // Contention from reset, 2-beat bursts, no idle bubble between grants
        pulse_reset();
        drive(1, 8'hB0, 0, 1, 8'hC0, 0, 1);
        cyc("t2_arb", 0, 8'h00, 0, 0, 0, 0, 0);
        cyc("t2_r0b0", 1, 8'hB0, 0, 1, 0, 0, 1);
        drive(1, 8'hB1, 1, 1, 8'hC0, 0, 1);
        cyc("t2_r0b1", 1, 8'hB1, 1, 1, 0, 0, 1);
        drive(1, 8'hB2, 0, 1, 8'hC0, 0, 1);
        cyc("t2_r1b0", 1, 8'hC0, 0, 0, 1, 1, 1);
        drive(1, 8'hB2, 0, 1, 8'hC1, 1, 1);
        cyc("t2_r1b1", 1, 8'hC1, 1, 0, 1, 1, 1);
        drive(1, 8'hB2, 1, 0, 8'h00, 0, 1);
        cyc("t2_r0again", 1, 8'hB2, 1, 1, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        cyc("t2_idle", 0, 8'h00, 0, 0, 0, 0, 0);

        // Forced release every 4 beats with the grant retained
        pulse_reset();
        drive(0, 8'h00, 0, 1, 8'h11, 0, 1);
        cyc("t3_arb", 0, 8'h00, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            drive(0, 8'h00, 0, 1, 8'(16 + k), 0, 1);
            cyc($sformatf("t3_b%0d", k), 1, 8'(16 + k), (k % 4) == 0, 0, 1, 1, 1);
        end
        // Valid drop mid-burst keeps the grant
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        cyc("t3_drop", 0, 8'h00, 0, 0, 1, 1, 1);
        drive(1, 8'h40, 0, 1, 8'h1B, 0, 1);
        cyc("t3_b11", 1, 8'h1B, 0, 0, 1, 1, 1);
        drive(1, 8'h40, 0, 1, 8'h1C, 0, 1);
        cyc("t3_b12", 1, 8'h1C, 1, 0, 1, 1, 1);

        // Backpressure on the new req0 grant: counter must not advance
        drive(1, 8'h55, 0, 0, 8'h00, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("t3_bp%0d", k), 1, 8'h55, 0, 0, 0, 0, 1);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 8'(8'h55 + k), 0, 0, 8'h00, 0, 1);
            cyc($sformatf("t3_rel%0d", k), 1, 8'(8'h55 + k), k == 3, 1, 0, 0, 1);
        end

        // Reset mid-burst at beat 2; prio (currently 1) must return to 0
        drive(1, 8'h60, 0, 0, 8'h00, 0, 1);
        cyc("t4_b1", 1, 8'h60, 0, 1, 0, 0, 1);
        drive(1, 8'h61, 0, 1, 8'h70, 0, 1);
        pulse_reset();
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        cyc("t4_rst", 0, 8'h00, 0, 0, 0, 0, 0);
        drive(1, 8'h61, 0, 1, 8'h70, 0, 1);
        cyc("t4_arb", 0, 8'h00, 0, 0, 0, 0, 0);
        cyc("t4_prio0", 1, 8'h61, 0, 1, 0, 0, 1);
        drive(1, 8'h62, 1, 0, 8'h00, 0, 1);
        cyc("t4_end", 1, 8'h62, 1, 1, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        cyc("t4_idle", 0, 8'h00, 0, 0, 0, 0, 0);

`ifdef ARB_STATS_EN
        // Beat statistics: 5 from req0, 3 from req1, then clear
        pulse_reset();
        drive(1, 8'h00, 0, 0, 8'h00, 0, 1);
        cyc("s_arb0", 0, 8'h00, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 8'(k), k == 4, 0, 8'h00, 0, 1);
            cyc($sformatf("s_r0b%0d", k), 1, 8'(k), (k == 3) || (k == 4), 1, 0, 0, 1);
        end
        drive(0, 8'h00, 0, 1, 8'h80, 0, 1);
        cyc("s_arb1", 0, 8'h00, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 8'h00, 0, 1, 8'(8'h80 + k), k == 2, 1);
            cyc($sformatf("s_r1b%0d", k), 1, 8'(8'h80 + k), k == 2, 0, 1, 1, 1);
        end
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        @(negedge clk);
        chk("stat0", 32'(stat0_beats), 32'd5);
        chk("stat1", 32'(stat1_beats), 32'd3);
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        stat_clear = 1'b0;
        @(negedge clk);
        chk("stat0_clr", 32'(stat0_beats), 32'd0);
        chk("stat1_clr", 32'(stat1_beats), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
